// File: rtl/updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter
//  Description : Parametrised synchronous up/down counter with parallel load,
//                wrap-or-saturate boundary handling, a registered rollover
//                pulse and a sticky terminal (done) flag.
//  Ports       : clk, rst         - rising-edge clock, sync active-high reset
//                enable           - advance one step this cycle
//                clear            - synchronous clear to 0
//                load, load_val   - parallel load (clamped to max)
//                dir              - 1 = up, 0 = down
//                wrap             - 1 = wrap at boundary, 0 = saturate
//                max              - inclusive upper bound (lower bound is 0)
//                count            - registered count
//                at_max, at_min   - combinational boundary flags
//                rollover         - one-cycle registered pulse on wrap
//                done             - sticky flag, set when saturation blocks a step
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic                load,
  input  logic [NUM_BITS-1:0] load_val,
  input  logic                dir,
  input  logic                wrap,
  input  logic [NUM_BITS-1:0] max,
  output logic [NUM_BITS-1:0] count,
  output logic                at_max,
  output logic                at_min,
  output logic                rollover,
  output logic                done
);

  localparam logic [NUM_BITS-1:0] c_zero = '0;
  localparam logic [NUM_BITS-1:0] c_one  = {{(NUM_BITS-1){1'b0}}, 1'b1};

  logic [NUM_BITS-1:0] count_q, count_d;
  logic                rollover_q, rollover_d;
  logic                done_q, done_d;

  always_comb begin
    count_d    = count_q;
    rollover_d = 1'b0;
    done_d     = done_q;

    if (clear) begin
      count_d = c_zero;
      done_d  = 1'b0;
    end else if (load) begin
      count_d = (load_val > max) ? max : load_val;
      done_d  = 1'b0;
    end else if (enable) begin
      if (dir) begin
        // Compare before incrementing so the all-ones value never wraps via +1.
        if (count_q >= max) begin
          if (wrap) begin
            count_d    = c_zero;
            rollover_d = 1'b1;
          end else begin
            count_d = max;
            done_d  = 1'b1;
          end
        end else begin
          count_d = count_q + c_one;
        end
      end else begin
        if (count_q > max) begin
          // max was lowered below the current count: snap to it silently.
          count_d = max;
        end else if (count_q != c_zero) begin
          count_d = count_q - c_one;
        end else if (wrap) begin
          count_d    = max;
          rollover_d = 1'b1;
        end else begin
          count_d = c_zero;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= c_zero;
      rollover_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= rollover_d;
      done_q     <= done_d;
    end
  end

  assign count    = count_q;
  assign rollover = rollover_q;
  assign done     = done_q;
  assign at_max   = (count_q == max);
  assign at_min   = (count_q == c_zero);

endmodule
`default_nettype wire

// File: tb/tb_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_counter
//  Description : Scoreboard bench for updown_counter (NUM_BITS = 8). A driver
//                applies directed and random stimulus just after each falling
//                edge and pushes the reference model's expected response; a
//                monitor pops and compares on the following falling edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [NB-1:0] load_val = '0;
  logic          dir = 1'b0;
  logic          wrap = 1'b0;
  logic [NB-1:0] max = '0;
  logic [NB-1:0] count;
  logic          at_max, at_min, rollover, done;

  updown_counter #(.NUM_BITS(NB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
    .load_val(load_val), .dir(dir), .wrap(wrap), .max(max),
    .count(count), .at_max(at_max), .at_min(at_min),
    .rollover(rollover), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            tgt;
    logic [NB-1:0] cnt;
    logic          ro;
    logic          dn;
    logic [NB-1:0] mx;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain integers).
  int m_count = 0;
  bit m_done  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every expectation whose target edge has passed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("count",    32'(count),    32'(e.cnt));
      chk("rollover", 32'(rollover), 32'(e.ro));
      chk("done",     32'(done),     32'(e.dn));
      chk("at_max",   32'(at_max),   32'(e.cnt == e.mx));
      chk("at_min",   32'(at_min),   32'(e.cnt == 0));
    end
  end

  task automatic step(input bit r, input bit c, input bit l, input int lv,
                      input bit e, input bit d, input bit w, input int mx);
    int  nc;
    bit  ro;
    exp_t x;
    @(negedge clk);
    #1;
    rst = r; clear = c; load = l; load_val = NB'(lv);
    enable = e; dir = d; wrap = w; max = NB'(mx);
    ro = 0;
    nc = m_count;
    if (r || c) begin
      nc = 0; m_done = 0;
    end else if (l) begin
      nc = (lv > mx) ? mx : lv; m_done = 0;
    end else if (e) begin
      if (d) begin
        if (m_count + 1 <= mx) nc = m_count + 1;
        else if (w) begin nc = 0; ro = 1; end
        else begin nc = mx; m_done = 1; end
      end else begin
        if (m_count > mx) nc = mx;
        else if (m_count - 1 >= 0) nc = m_count - 1;
        else if (w) begin nc = mx; ro = 1; end
        else begin nc = 0; m_done = 1; end
      end
    end
    m_count = nc;
    x.tgt = cyc + 1;
    x.cnt = NB'(nc);
    x.ro  = ro;
    x.dn  = m_done;
    x.mx  = NB'(mx);
    q.push_back(x);
  endtask

  // Shorthand for a plain enabled count step.
  task automatic cnt(input bit d, input bit w, input int mx);
    step(0, 0, 0, 0, 1, d, w, mx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with enable, then release.
    step(1, 0, 0, 0, 1, 1, 0, 255);
    step(1, 0, 0, 0, 1, 1, 0, 255);
    cnt(1, 0, 255);

    // Up with wrap, max = 9.
    step(0, 1, 0, 0, 0, 1, 1, 9);
    for (int i = 0; i < 12; i++) cnt(1, 1, 9);

    // Down with saturate from 3, then clear.
    step(0, 0, 1, 3, 0, 0, 0, 255);
    for (int i = 0; i < 5; i++) cnt(0, 0, 255);
    step(0, 1, 0, 0, 0, 0, 0, 255);

    // Priority: clear over load over enable; load over enable.
    step(0, 1, 1, 50, 1, 1, 1, 255);
    step(0, 0, 1, 50, 1, 1, 1, 255);

    // Load clamp, then lowered max with wrap up / down.
    step(0, 0, 1, 200, 0, 1, 1, 20);
    cnt(1, 1, 20);
    step(0, 0, 1, 200, 0, 1, 1, 20);
    cnt(1, 1, 10);
    step(0, 0, 1, 200, 0, 0, 1, 20);
    cnt(0, 1, 10);

    // Direction flip from 5.
    step(0, 0, 1, 5, 0, 1, 1, 255);
    for (int i = 0; i < 4; i++) cnt(i % 2 == 0, 1, 255);

    // max = 0 with wrap, then saturate.
    for (int i = 0; i < 3; i++) cnt(i % 2 == 0, 1, 0);
    for (int i = 0; i < 2; i++) cnt(1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    // All-ones count with max = 255 and saturate.
    step(0, 0, 1, 255, 0, 1, 0, 255);
    cnt(1, 0, 255);
    cnt(1, 1, 255);

    // Randomized traffic; small max values make boundaries frequent.
    for (int i = 0; i < 600; i++) begin
      int mx;
      mx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 12));
      step($urandom_range(0, 40) == 0, $urandom_range(0, 25) == 0,
           $urandom_range(0, 12) == 0, int'($urandom_range(0, 255)),
           $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, mx);
    end

    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/updown_counter.md
# updown_counter

Parametrised synchronous up/down counter: the general-purpose successor to the fixed 8-bit `counter_8`. It adds configurable width, count direction, parallel load, wrap-or-saturate selection, a registered rollover pulse and a sticky terminal flag. It serves as the timing/event counter for timers, baud dividers and FSM dwell counters. It is a standalone leaf block with no submodules.

## Interface
- `NUM_BITS`, default 8: counter width; legal range 2–32.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: advance the count one step this cycle.
- `clear`  in  1: synchronous clear to 0.
- `load`  in  1: parallel load of `load_val`.
- `load_val`  in  NUM_BITS: value to load.
- `dir`  in  1: 1 = count up, 0 = count down.
- `wrap`  in  1: 1 = wrap at the boundary, 0 = saturate at the boundary.
- `max`  in  NUM_BITS: upper bound, inclusive. The lower bound is fixed at 0.
- `count`  out  NUM_BITS: current count; registered.
- `at_max`  out  1: `count == max`; combinational.
- `at_min`  out  1: `count == 0`; combinational.
- `rollover`  out  1: one-cycle registered pulse on a wrap event.
- `done`  out  1: sticky; set when a saturating boundary blocks a step.

## Operation
- Priority per rising edge: `rst` > `clear` > `load` > `enable` > hold.
- `rst` or `clear`: `count`=0, `rollover`=0, `done`=0.
- `load`:
  - `count` = `load_val` if `load_val` ≤ `max`, otherwise `count` = `max`.
  - `rollover`=0, `done`=0.
  - `enable` is ignored that cycle.
- `enable` with `dir`=1 (up):
  - `count` < `max`: `count`+1.
  - `count` ≥ `max` and `wrap`=1: `count`=0, `rollover`=1.
  - `count` ≥ `max` and `wrap`=0: `count`=`max`, `done`=1.
- `enable` with `dir`=0 (down):
  - `count` > `max` (because `max` was lowered): `count`=`max`, with no rollover or done.
  - `count` > 0: `count`−1.
  - `count`=0 and `wrap`=1: `count`=`max`, `rollover`=1.
  - `count`=0 and `wrap`=0: `count` holds 0, `done`=1.
- Idle (no `enable`, `load`, `clear` or `rst`): `count` holds, `done` holds, `rollover`=0.
- `rollover` is high only in the cycle after a wrap event, and is deasserted on every other edge.
- `done` stays set until `rst`, `clear` or `load`. Counting continues to saturate while `done` is high.
- `max`=0: `count` is pinned at 0 and `at_max`=`at_min`=1.
  - With `wrap`=1, every enabled cycle produces a `rollover` pulse.
  - With `wrap`=0, the first enabled cycle sets `done`.
- `max` may change at any time and takes effect on the next edge. No output glitch requirement applies to the combinational flags.
- Arithmetic is unsigned at NUM_BITS width with no internal overflow. The compare `count` ≥ `max` is done before incrementing, so `count`=2^N−1 never wraps through +1.
- `dir`, `wrap` and `max` are sampled on every edge, so direction may change cycle to cycle.

## Timing
- Reset values: `count`=0, `rollover`=0, `done`=0. Hence `at_min`=1, and `at_max` = (`max`==0).
- Latency from input to `count`, `rollover` or `done` is 1 clock.
- `at_max` and `at_min` follow `count` in the same cycle with no added latency.
- Reset asserted mid-count takes effect on the next edge regardless of `enable`, `load` or `clear`.
- Counting resumes on the first edge after `rst` deasserts if `enable` is high. With `dir`=1, `count`=1 one edge after release.
- All inputs are sampled on the rising edge only. Stimulus changes on the falling edge, and checks are made on the falling edge.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `enable`=1, `dir`=1, `max`=8'hFF → `count`=0, `rollover`=0, `done`=0, `at_min`=1. Release → `count`=1 after one edge.
- Up with wrap: `max`=8'd9, `wrap`=1, `dir`=1, 12 enabled cycles from 0.
  - `count` runs 1..9 then 0, 1, 2.
  - `at_max` is high only while `count`=9.
  - `rollover` is high for exactly one cycle, coincident with `count`=0.
- Down with saturate: `load_val`=8'd3, `load`=1, then `dir`=0, `wrap`=0, 5 enabled cycles.
  - `count` runs 2, 1, 0, 0, 0.
  - `done` rises on the 4th cycle and stays high.
  - A subsequent `clear` drops `done` to 0.
- Priority: `clear`=1, `load`=1 (`load_val`=8'd50) and `enable`=1 together → `count`=0. Then `load`=1 with `enable`=1 → `count`=50, not 51.
- Load clamp and lowered max:
  - `max`=8'd20, `load_val`=8'd200 → `count`=20.
  - Count up to 20, then set `max`=8'd10 with `dir`=1, `wrap`=1 → `count`=0 with a `rollover` pulse.
  - Repeat with `dir`=0 → `count`=10.
- Direction flip and `max`=0:
  - Alternating `dir` each cycle from `count`=5, `max`=8'hFF → `count` alternates 6, 5, 6, 5.
  - `max`=0, `wrap`=1 → `count` stays 0 and `rollover` is high every enabled cycle.
